// File: rtl/clk_meter.sv
// Measures the period and high time of a slow asynchronous clock (clk_in)
// in clk cycles, one measurement per accepted start, with a timeout abort.
module clk_meter #(
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TIMEOUT     = 32'd10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout,
    output logic             clk_in_rise
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   rise, fall;
    logic                   clk_in_rise_q, clk_in_rise_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   time_up;

    // Shift chain: stage 0 samples the raw asynchronous input.
    assign sync_d[0] = clk_in;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign hist_d        = sync_q[SYNC_STAGES-1];
    assign rise          = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall          = ~sync_q[SYNC_STAGES-1] & hist_q;
    assign clk_in_rise_d = rise;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    // Abort on the edge where the counter would reach TIMEOUT.
    assign time_up = (cnt_inc >= TIMEOUT_C);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cap_d    = hi_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARM;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ARM: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    state_d = MEAS_HIGH;
                    cnt_d   = CNT_ONE;
                end else if (time_up) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            MEAS_HIGH: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    hi_cap_d = cnt_q;
                    state_d  = MEAS_LOW;
                end else if (time_up) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            MEAS_LOW: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_cap_q;
                    valid_d     = 1'b1;
                    state_d     = IDLE;
                end else if (time_up) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            hist_q        <= 1'b0;
            clk_in_rise_q <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_cap_q      <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            hist_q        <= hist_d;
            clk_in_rise_q <= clk_in_rise_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_cap_q      <= hi_cap_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign valid       = valid_q;
    assign period      = period_q;
    assign high_time   = high_time_q;
    assign timeout     = timeout_q;
    assign clk_in_rise = clk_in_rise_q;

endmodule

// File: tb/tb_clk_meter.sv
// Directed bench for clk_meter: duty/period measurements, timeouts,
// start filtering and asynchronous reset, with TIMEOUT set to 100.
module tb_clk_meter;

    logic        clk;
    logic        rst_n;
    logic        clk_in;
    logic        start;
    logic        busy;
    logic        valid;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        timeout;
    logic        clk_in_rise;

    logic        gen_en;
    logic        gen_clk;
    logic        man_clk;
    int          hi_len;
    int          lo_len;

    int          n_checks;
    int          n_fail;

    clk_meter #(
        .SYNC_STAGES(2),
        .CNT_W      (32),
        .TIMEOUT    (32'd100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_in     (clk_in),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .period     (period),
        .high_time  (high_time),
        .timeout    (timeout),
        .clk_in_rise(clk_in_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waveform source for clk_in, changing 1 ns after a rising clk edge.
    initial gen_clk = 1'b0;
    always begin
        if (gen_en) begin
            gen_clk = 1'b1;
            repeat (hi_len) @(posedge clk);
            #1;
            gen_clk = 1'b0;
            repeat (lo_len) @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
        end
    end

    assign clk_in = gen_en ? gen_clk : man_clk;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit found, output int lat);
        found = 1'b0;
        lat   = 0;
        while (lat < budget && !found) begin
            if (valid === 1'b1) found = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (period !== 32'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
        n_checks++; if (high_time !== 32'd0) begin n_fail++; $display("FAIL reset_high: got %0d want 0", high_time); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_checks++; if (clk_in_rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b want 0", clk_in_rise); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic measure(input string name, input int hi, input int lo);
        bit found;
        int lat;
        hi_len = hi;
        lo_len = lo;
        gen_en = 1'b1;
        repeat (3 * (hi + lo)) @(negedge clk);
        pulse_start();
        wait_valid(100, found, lat);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_valid: no valid within 100 cycles", name);
        end else begin
            n_checks++;
            if (period !== 32'(hi + lo)) begin
                n_fail++; $display("FAIL %s_period: got %0d want %0d", name, period, hi + lo);
            end
            n_checks++;
            if (high_time !== 32'(hi)) begin
                n_fail++; $display("FAIL %s_high: got %0d want %0d", name, high_time, hi);
            end
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL %s_after: valid=%b busy=%b want 0 0", name, valid, busy);
            end
        end
        $display("measure %s: period=%0d high_time=%0d", name, period, high_time);
    endtask

    task automatic test_basic();
        measure("basic_5_5", 5, 5);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_duty();
        measure("duty_3_7", 3, 7);
        measure("duty_8_12", 8, 12);
    endtask

    task automatic test_timeout_low();
        int  lat;
        bit  seen_valid;
        gen_en  = 1'b0;
        man_clk = 1'b0;
        repeat (40) @(negedge clk);
        pulse_start();
        lat = 0;
        seen_valid = 1'b0;
        while (busy === 1'b1 && lat < 200) begin
            if (valid === 1'b1) seen_valid = 1'b1;
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat < 99 || lat > 101) begin n_fail++; $display("FAIL tmo_low_time: got %0d cycles want 100", lat); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_low_flag: got %b want 1", timeout); end
        n_checks++; if (seen_valid) begin n_fail++; $display("FAIL tmo_low_valid: got pulse want none"); end
        n_checks++; if (period !== 32'd20 || high_time !== 32'd8) begin
            n_fail++; $display("FAIL tmo_low_hold: got %0d/%0d want 20/8", period, high_time);
        end
        $display("timeout_low: abort after %0d cycles", lat);
    endtask

    task automatic test_timeout_high();
        int lat;
        pulse_start();
        repeat (9) @(negedge clk);
        man_clk = 1'b1;
        lat = 9;
        while (busy === 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat < 108 || lat > 114) begin n_fail++; $display("FAIL tmo_high_time: got %0d cycles want 111", lat); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_high_flag: got %b want 1", timeout); end
        pulse_start();
        n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL tmo_clear: timeout=%b busy=%b want 0 1", timeout, busy);
        end
        lat = 0;
        while (busy === 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_rearm_end: busy got %b want 0", busy); end
        man_clk = 1'b0;
        repeat (10) @(negedge clk);
        $display("timeout_high: abort after %0d cycles", lat);
    endtask

    task automatic test_start_filter();
        bit found;
        int lat;
        hi_len = 5;
        lo_len = 5;
        gen_en = 1'b1;
        repeat (30) @(negedge clk);
        pulse_start();
        lat = 0;
        while (clk_in_rise !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(50, found, lat);
        n_checks++;
        if (!found || period !== 32'd10 || high_time !== 32'd5) begin
            n_fail++; $display("FAIL restart_ignored: found=%b got %0d/%0d want 10/5", found, period, high_time);
        end
        // A rise seen at this negedge repeats 10 cycles later; start lands on it.
        lat = 0;
        while (clk_in_rise !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(60, found, lat);
        n_checks++;
        if (!found || lat != 20) begin
            n_fail++; $display("FAIL coincident_rise: found=%b latency %0d want 20", found, lat);
        end
        n_checks++; if (period !== 32'd10 || high_time !== 32'd5) begin
            n_fail++; $display("FAIL coincident_result: got %0d/%0d want 10/5", period, high_time);
        end
        $display("start_filter: coincident latency=%0d", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        pulse_start();
        lat = 0;
        while (clk_in_rise !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0 || clk_in_rise !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: busy=%b valid=%b timeout=%b rise=%b want 0", busy, valid, timeout, clk_in_rise);
        end
        n_checks++; if (period !== 32'd0 || high_time !== 32'd0) begin
            n_fail++; $display("FAIL midrst_data: got %0d/%0d want 0/0", period, high_time);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("reset_mid: async reset applied");
        measure("post_reset", 5, 5);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        gen_en   = 1'b0;
        man_clk  = 1'b0;
        hi_len   = 5;
        lo_len   = 5;
        rst_n    = 1'b0;
        test_reset();
        test_basic();
        test_duty();
        test_timeout_low();
        test_timeout_high();
        test_start_filter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
